// File: rtl/datapath.sv
// Single-cycle MIPS-style datapath: PC, 32x n register file, sign extender, ALU, next-PC and writeback muxes.
// Define DATAPATH_ALU_EXT_EN to add the xor/nor/sll ALU operations; ports are the same either way.
module datapath #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         memtoreg,
  input  logic         pcsrc,
  input  logic         alusrc,
  input  logic         regdst,
  input  logic         regwrite,
  input  logic         jump,
  input  logic [2:0]   alucontrol,
  output logic         zero,
  output logic [n-1:0] pc,
  input  logic [n-1:0] instr,
  output logic [n-1:0] aluout,
  output logic [n-1:0] writedata,
  input  logic [n-1:0] readdata
);

  logic [n-1:0] rf [32];
  logic [4:0]   rs, rt, rd, wa;
  logic [n-1:0] srca, srcb, signimm, result;
  logic [n-1:0] pcplus4, pcbranch, jumptarget, pcnext;

  assign rs = instr[25:21];
  assign rt = instr[20:16];
  assign rd = instr[15:11];
  assign wa = regdst ? rd : rt;

  // Register 0 is hardwired to zero on read; writes to it are dropped below.
  assign srca      = (rs == 5'd0) ? '0 : rf[rs];
  assign writedata = (rt == 5'd0) ? '0 : rf[rt];

  assign signimm = {{(n-16){instr[15]}}, instr[15:0]};
  assign srcb    = alusrc ? signimm : writedata;
  assign result  = memtoreg ? readdata : aluout;

  always_comb begin
    aluout = '0;
    case (alucontrol)
      3'b010: aluout = srca + srcb;
      3'b110: aluout = srca - srcb;
      3'b000: aluout = srca & srcb;
      3'b001: aluout = srca | srcb;
      3'b111: aluout = {{(n-1){1'b0}}, ($signed(srca) < $signed(srcb))};
`ifdef DATAPATH_ALU_EXT_EN
      3'b011: aluout = srca ^ srcb;
      3'b100: aluout = ~(srca | srcb);
      3'b101: aluout = srcb << instr[10:6];
`endif
      default: aluout = '0;
    endcase
  end

  assign zero = (aluout == '0);

  // The jump target keeps the top nibble of pc+4 and zero-extends when n exceeds 32.
  assign pcplus4    = pc + n'(4);
  assign pcbranch   = pcplus4 + (signimm << 2);
  assign jumptarget = n'({pcplus4[n-1:n-4], instr[25:0], 2'b00});
  assign pcnext     = jump ? jumptarget : (pcsrc ? pcbranch : pcplus4);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      pc <= pcnext;
      if (regwrite && (wa != 5'd0)) rf[wa] <= result;
    end
  end

  // Opcode/funct bits are decoded by the external controller, not here.
  logic unused_fields;
`ifdef DATAPATH_ALU_EXT_EN
  assign unused_fields = &{1'b0, instr[n-1:26]};
`else
  assign unused_fields = &{1'b0, instr[n-1:26], instr[10:6]};
`endif

endmodule

// File: tb/tb_datapath.sv
// Directed table-driven bench for datapath: ALU/regfile vectors in a table, then hand-written
// reset, branch and jump sequences.
module tb_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic        memtoreg, pcsrc, alusrc, regdst, regwrite, jump;
  logic [2:0]  alucontrol;
  logic        zero;
  logic [31:0] pc, instr, aluout, writedata, readdata;

  int compared = 0;
  int mismatched = 0;

  datapath #(.n(32)) dut (
    .clk(clk), .reset(reset), .memtoreg(memtoreg), .pcsrc(pcsrc), .alusrc(alusrc),
    .regdst(regdst), .regwrite(regwrite), .jump(jump), .alucontrol(alucontrol),
    .zero(zero), .pc(pc), .instr(instr), .aluout(aluout), .writedata(writedata),
    .readdata(readdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  alucontrol;
    logic        alusrc, regdst, regwrite, memtoreg, pcsrc, jump;
    logic [31:0] readdata;
    logic [31:0] exp_aluout;
    logic        exp_zero;
    logic [31:0] exp_writedata;
  } vec_t;

  vec_t vecs [16];

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh);
    return {6'd0, rs, rt, rd, sh, 6'h20};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic vec_t row(input logic [31:0] ins, input logic [2:0] ac,
                               input logic as, input logic rdst, input logic rw,
                               input logic mr, input logic [31:0] rdata,
                               input logic [31:0] eal, input logic ez,
                               input logic [31:0] ewd);
    vec_t v;
    v.instr = ins; v.alucontrol = ac; v.alusrc = as; v.regdst = rdst;
    v.regwrite = rw; v.memtoreg = mr; v.pcsrc = 1'b0; v.jump = 1'b0;
    v.readdata = rdata; v.exp_aluout = eal; v.exp_zero = ez; v.exp_writedata = ewd;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    instr = v.instr; alucontrol = v.alucontrol; alusrc = v.alusrc; regdst = v.regdst;
    regwrite = v.regwrite; memtoreg = v.memtoreg; pcsrc = v.pcsrc; jump = v.jump;
    readdata = v.readdata;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    vec_t v;
    logic [31:0] x_xor, x_nor, x_sll, z_ext;
`ifdef DATAPATH_ALU_EXT_EN
    x_xor = 32'h0000_001E; x_nor = 32'hFFFF_FFE1; x_sll = 32'h0000_0050; z_ext = 32'd0;
`else
    x_xor = 32'd0; x_nor = 32'd0; x_sll = 32'd0; z_ext = 32'd1;
`endif
    // Register state after each row: r5=10, r7=20, r6=ABCD1234; r0 stays 0.
    vecs[0]  = row(itype(6'h08, 5'd1, 5'd5, 16'd10), 3'b010, 1, 0, 1, 0, 32'd0, 32'd10, 0, 32'd0);
    vecs[1]  = row(rtype(5'd5, 5'd5, 5'd7, 5'd0), 3'b010, 0, 1, 1, 0, 32'd0, 32'd20, 0, 32'd10);
    vecs[2]  = row(itype(6'h23, 5'd0, 5'd6, 16'd4), 3'b010, 1, 0, 1, 1, 32'hABCD1234, 32'd4, 0, 32'd0);
    vecs[3]  = row(rtype(5'd7, 5'd6, 5'd0, 5'd0), 3'b010, 0, 1, 0, 0, 32'd0, 32'hABCD1248, 0, 32'hABCD1234);
    vecs[4]  = row(rtype(5'd5, 5'd5, 5'd0, 5'd0), 3'b110, 0, 1, 0, 0, 32'd0, 32'd0, 1, 32'd10);
    vecs[5]  = row(rtype(5'd6, 5'd7, 5'd0, 5'd0), 3'b000, 0, 1, 0, 0, 32'd0, 32'h14, 0, 32'h14);
    vecs[6]  = row(rtype(5'd5, 5'd7, 5'd0, 5'd0), 3'b001, 0, 1, 0, 0, 32'd0, 32'h1E, 0, 32'h14);
    vecs[7]  = row(rtype(5'd6, 5'd5, 5'd0, 5'd0), 3'b111, 0, 1, 0, 0, 32'd0, 32'd1, 0, 32'd10);
    vecs[8]  = row(rtype(5'd5, 5'd6, 5'd0, 5'd0), 3'b111, 0, 1, 0, 0, 32'd0, 32'd0, 1, 32'hABCD1234);
    vecs[9]  = row(itype(6'h08, 5'd5, 5'd0, 16'hFFFF), 3'b010, 1, 0, 0, 0, 32'd0, 32'd9, 0, 32'd0);
    vecs[10] = row(itype(6'h0A, 5'd5, 5'd0, 16'hFFFF), 3'b111, 1, 0, 0, 0, 32'd0, 32'd0, 1, 32'd0);
    vecs[11] = row(rtype(5'd5, 5'd7, 5'd0, 5'd0), 3'b011, 0, 1, 0, 0, 32'd0, x_xor, z_ext[0], 32'h14);
    vecs[12] = row(rtype(5'd5, 5'd7, 5'd0, 5'd0), 3'b100, 0, 1, 0, 0, 32'd0, x_nor, z_ext[0], 32'h14);
    vecs[13] = row(rtype(5'd5, 5'd7, 5'd0, 5'd2), 3'b101, 0, 1, 0, 0, 32'd0, x_sll, z_ext[0], 32'h14);
    vecs[14] = row(itype(6'h08, 5'd5, 5'd0, 16'd7), 3'b010, 1, 0, 1, 0, 32'd0, 32'h11, 0, 32'd0);
    vecs[15] = row(rtype(5'd0, 5'd0, 5'd0, 5'd0), 3'b010, 0, 1, 0, 0, 32'd0, 32'd0, 1, 32'd0);

    v = row(32'd0, 3'b000, 0, 0, 0, 0, 32'd0, 32'd0, 1, 32'd0);
    applyStimulus(v);
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1 checkOutput("reset_pc", pc, 32'd0);
    checkOutput("reset_reg_read", writedata, 32'd0);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      #1 checkOutput("pc_increment", pc, 32'(4 * k));
    end

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d_pc", i), pc, 32'(12 + 4 * i));
      checkOutput($sformatf("v%0d_aluout", i), aluout, vecs[i].exp_aluout);
      checkOutput($sformatf("v%0d_zero", i), {31'd0, zero}, {31'd0, vecs[i].exp_zero});
      checkOutput($sformatf("v%0d_writedata", i), writedata, vecs[i].exp_writedata);
    end

    // Mid-run reset with regwrite held high: no write may land and all state clears.
    @(negedge clk);
    v = row(itype(6'h08, 5'd5, 5'd5, 16'd99), 3'b010, 1, 0, 1, 0, 32'd0, 32'd0, 0, 32'd0);
    applyStimulus(v);
    reset = 1'b1;
    @(posedge clk);
    #1 checkOutput("midreset_pc", pc, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    v = row(rtype(5'd5, 5'd6, 5'd0, 5'd0), 3'b010, 0, 1, 0, 0, 32'd0, 32'd0, 1, 32'd0);
    applyStimulus(v);
    #1 checkOutput("midreset_r5", aluout, 32'd0);
    checkOutput("midreset_r6", writedata, 32'd0);
    v = row(rtype(5'd7, 5'd0, 5'd0, 5'd0), 3'b010, 0, 1, 0, 0, 32'd0, 32'd0, 1, 32'd0);
    applyStimulus(v);
    #1 checkOutput("midreset_r7", aluout, 32'd0);

    v = row(32'd0, 3'b000, 0, 0, 0, 0, 32'd0, 32'd0, 1, 32'd0);
    applyStimulus(v);
    for (int k = 0; k < 4; k++) @(negedge clk);
    #1 checkOutput("pre_branch_pc", pc, 32'h10);
    v = row(itype(6'h04, 5'd0, 5'd0, 16'hFFFF), 3'b110, 0, 0, 0, 0, 32'd0, 32'd0, 1, 32'd0);
    v.pcsrc = 1'b1;
    applyStimulus(v);
    @(negedge clk);
    #1 checkOutput("branch_back_pc", pc, 32'h10);
    v.instr = itype(6'h04, 5'd0, 5'd0, 16'd3);
    applyStimulus(v);
    @(negedge clk);
    #1 checkOutput("branch_fwd_pc", pc, 32'h20);
    v.instr = {6'h02, 26'h40};
    v.jump = 1'b1;
    applyStimulus(v);
    @(negedge clk);
    #1 checkOutput("jump_pc", pc, 32'h100);
    v = row(32'd0, 3'b000, 0, 0, 0, 0, 32'd0, 32'd0, 1, 32'd0);
    applyStimulus(v);
    @(negedge clk);
    #1 checkOutput("post_jump_pc", pc, 32'h104);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
